// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types for mem_block_arbiter (FSM states, port indices)
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    RELEASE = 2'd2,
    DRAIN   = 2'd3
  } state_t;

  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;

endpackage

// File: rtl/mem_arb_grant.sv
// rtl/mem_arb_grant.sv - 2-way grant; MEM_ARB_RR_EN selects round-robin, else port 1 wins ties
module mem_arb_grant
  import mem_arb_pkg::*;
(
  input  logic valid0,
  input  logic valid1,
  input  logic last,
  output logic grant
);

`ifndef MEM_ARB_RR_EN
  logic unused_last;
  assign unused_last = last;
`endif

  always_comb begin
    grant = PORT_I;
    if (valid0 && valid1) begin
`ifdef MEM_ARB_RR_EN
      grant = ~last;
`else
      grant = PORT_D;
`endif
    end else if (valid1) begin
      grant = PORT_D;
    end
  end

endmodule

// File: rtl/mem_block_arbiter.sv
// rtl/mem_block_arbiter.sv - two-port arbiter/sequencer for the block memory; MEM_ARB_RR_EN enables round-robin
module mem_block_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DATA_WIDTH         = 32,
  parameter int ADDR_WIDTH         = 10,
  parameter int BLOCK_OFFSET_WIDTH = 3,
  parameter int BLOCK_SIZE         = 1 << BLOCK_OFFSET_WIDTH
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             req0_valid,
  input  logic [ADDR_WIDTH-1:0]            req0_addr,
  output logic                             req0_ready,
  output logic                             resp0_valid,
  input  logic                             req1_valid,
  input  logic                             req1_we,
  input  logic [ADDR_WIDTH-1:0]            req1_addr,
  input  logic [BLOCK_SIZE*DATA_WIDTH-1:0] req1_wdata,
  output logic                             req1_ready,
  output logic                             resp1_valid,
  output logic [BLOCK_SIZE*DATA_WIDTH-1:0] resp_data,
  output logic [ADDR_WIDTH-1:0]            mem_addr,
  output logic                             mem_we,
  output logic [BLOCK_SIZE*DATA_WIDTH-1:0] mem_block_din,
  input  logic                             mem_block_valid,
  input  logic [BLOCK_SIZE*DATA_WIDTH-1:0] mem_block_dout
);

  // Flipping the block-offset-adjacent bit moves to a neighbouring block, forcing the memory to re-arm.
  localparam logic [ADDR_WIDTH-1:0] REL_FLIP = ADDR_WIDTH'(BLOCK_SIZE);

  state_t state, state_next;
  logic   grant;
  logic   last;
  logic   port_q;
  logic   sel;
  logic   accept;

  mem_arb_grant u_grant (
    .valid0 (req0_valid),
    .valid1 (req1_valid),
    .last   (last),
    .grant  (grant)
  );

  assign req0_ready = !rst && (state == IDLE) && req0_valid && (grant == PORT_I);
  assign req1_ready = !rst && (state == IDLE) && req1_valid && (grant == PORT_D);
  assign accept     = req0_ready || req1_ready;
  assign sel        = req1_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = BUSY;
      BUSY:    if (mem_block_valid) state_next = RELEASE;
      RELEASE: state_next = DRAIN;
      DRAIN:   if (!mem_block_valid) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_addr      <= '0;
      mem_we        <= 1'b0;
      mem_block_din <= '0;
      resp_data     <= '0;
      resp0_valid   <= 1'b0;
      resp1_valid   <= 1'b0;
      port_q        <= PORT_I;
      last          <= PORT_D;
    end else begin
      resp0_valid <= 1'b0;
      resp1_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            port_q        <= sel;
            last          <= sel;
            mem_addr      <= sel ? req1_addr : req0_addr;
            mem_we        <= sel & req1_we;
            mem_block_din <= sel ? req1_wdata : '0;
          end
        end
        BUSY: begin
          if (mem_block_valid) begin
            resp_data   <= mem_block_dout;
            resp0_valid <= (port_q == PORT_I);
            resp1_valid <= (port_q == PORT_D);
            mem_addr    <= mem_addr ^ REL_FLIP;
            mem_we      <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
